d_latch_checker: RTL and testbench



---
 rtl/d_latch_chk_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/d_latch_checker.sv | 112 +++++++++++
 tb/tb_d_latch_checker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/d_latch_chk_pkg.sv
// Shared types and error codes for the D latch output checker.
package d_latch_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRANSP = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_TRANSP = 2'b01;
  localparam logic [1:0] ERR_HOLD   = 2'b10;
  localparam logic [1:0] ERR_COMPL  = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/d_latch_checker.sv
// Observer for a D latch: transparency, hold and complement checks.
// Define D_LATCH_CHECKER_STICKY_EN to add first-error capture outputs.
module d_latch_checker
  import d_latch_chk_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d,
  input  logic             q,
  input  logic             q_bar,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic [CYC_W-1:0] cycle
`ifdef D_LATCH_CHECKER_STICKY_EN
  ,
  output logic             first_err_valid,
  output logic [1:0]       first_err_code,
  output logic [CYC_W-1:0] first_err_cycle
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_exp_q;
  logic             r_err;
  logic [1:0]       r_code;
  logic [1:0]       w_code;
  logic             w_err;
  logic [CYC_W-1:0] r_cycle;

  // Check mode follows the gate of the current sample, so the first
  // open or closed sample is already judged in its new mode.
  always_comb begin
    w_state_nxt = r_state;
    w_code      = ERR_NONE;
    case (r_state)
      IDLE: begin
        if (en) w_state_nxt = TRANSP;
      end
      TRANSP, HOLD: begin
        w_state_nxt = en ? TRANSP : HOLD;
        if (q_bar == q) begin
          w_code = ERR_COMPL;
        end else if (en && (q != d)) begin
          w_code = ERR_TRANSP;
        end else if (!en && (q != r_exp_q)) begin
          w_code = ERR_HOLD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_err = (w_code != ERR_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_exp_q <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
      r_cycle <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (en) r_exp_q <= d;
      r_err   <= w_err;
      r_code  <= w_code;
      r_cycle <= r_cycle + 1'b1;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_err),
    .count (err_count)
  );

  assign err      = r_err;
  assign err_code = r_code;
  assign cycle    = r_cycle;

`ifdef D_LATCH_CHECKER_STICKY_EN
  logic             r_fe_valid;
  logic [1:0]       r_fe_code;
  logic [CYC_W-1:0] r_fe_cycle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fe_valid <= 1'b0;
      r_fe_code  <= ERR_NONE;
      r_fe_cycle <= '0;
    end else if (w_err && !r_fe_valid) begin
      r_fe_valid <= 1'b1;
      r_fe_code  <= w_code;
      r_fe_cycle <= r_cycle;
    end
  end

  assign first_err_valid = r_fe_valid;
  assign first_err_code  = r_fe_code;
  assign first_err_cycle = r_fe_cycle;
`endif

endmodule

// File: tb/tb_d_latch_checker.sv
// Directed bench for d_latch_checker with a reference-value model.
module tb_d_latch_checker;

  localparam int CNT_W = 2;
  localparam int CYC_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, d, q, q_bar;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] err_count;
  logic [CYC_W-1:0] cycle;
`ifdef D_LATCH_CHECKER_STICKY_EN
  logic             first_err_valid;
  logic [1:0]       first_err_code;
  logic [CYC_W-1:0] first_err_cycle;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  d_latch_checker #(
    .CNT_W (CNT_W),
    .CYC_W (CYC_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .d               (d),
    .q               (q),
    .q_bar           (q_bar),
    .err             (err),
    .err_code        (err_code),
    .err_count       (err_count),
    .cycle           (cycle)
`ifdef D_LATCH_CHECKER_STICKY_EN
    ,
    .first_err_valid (first_err_valid),
    .first_err_code  (first_err_code),
    .first_err_cycle (first_err_cycle)
`endif
  );

  // Model: "known" means a gate-open sample has been seen since reset;
  // m_ref is the d value of the most recent gate-open sample.
  logic             m_known;
  logic             m_ref;
  logic [1:0]       m_code;
  int               m_cnt;
  int               m_cyc;
  logic [1:0]       m_next;
  logic             m_fv;
  logic [1:0]       m_fc;
  int               m_fcyc;

  function automatic logic [1:0] judge(input logic kn, input logic rf,
                                       input logic e, input logic dd,
                                       input logic qq, input logic qb);
    if (!kn) return 2'b00;
    if (qb == qq) return 2'b11;
    if (e && qq != dd) return 2'b01;
    if (!e && qq != rf) return 2'b10;
    return 2'b00;
  endfunction

  assign m_next = judge(m_known, m_ref, en, d, q, q_bar);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_known <= 1'b0;
      m_ref   <= 1'b0;
      m_code  <= 2'b00;
      m_cnt   <= 0;
      m_cyc   <= 0;
      m_fv    <= 1'b0;
      m_fc    <= 2'b00;
      m_fcyc  <= 0;
    end else begin
      m_code <= m_next;
      if (m_next != 2'b00 && m_cnt < (1 << CNT_W) - 1) m_cnt <= m_cnt + 1;
      m_cyc <= (m_cyc + 1) % (1 << CYC_W);
      if (en) begin
        m_known <= 1'b1;
        m_ref   <= d;
      end
      if (m_next != 2'b00 && !m_fv) begin
        m_fv   <= 1'b1;
        m_fc   <= m_next;
        m_fcyc <= m_cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("err", 32'(err), 32'(m_code != 2'b00));
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("err_count", 32'(err_count), 32'(m_cnt));
      chk("cycle", 32'(cycle), 32'(m_cyc));
`ifdef D_LATCH_CHECKER_STICKY_EN
      chk("first_valid", 32'(first_err_valid), 32'(m_fv));
      chk("first_code", 32'(first_err_code), 32'(m_fc));
      chk("first_cycle", 32'(first_err_cycle), 32'(m_fcyc));
`endif
    end
  end

  task automatic apply(input logic e, input logic dd, input logic qq,
                       input logic qb);
    en = e; d = dd; q = qq; q_bar = qb;
    @(posedge clk);
    #1;
  endtask

  int sat_cyc;

  initial begin
    rst_n = 1'b0;
    en = 0; d = 0; q = 0; q_bar = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_err", 32'(err), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_count", 32'(err_count), 0);
    chk("rst_cycle", 32'(cycle), 0);
    rst_n = 1'b1;

    // Idle: gate closed, outputs arbitrary and even non-complementary
    for (int i = 0; i < 10; i++) begin
      logic [1:0] v;
      v = 2'(i);
      apply(1'b0, v[0], v[1], v[0]);
    end
    chk("idle_cycle", 32'(cycle), 10);
    chk("idle_count", 32'(err_count), 0);

    apply(1, 1, 1, 0);
    repeat (5) apply(0, 0, 1, 0);
    chk("hold_ok_count", 32'(err_count), 0);

    apply(0, 0, 0, 1);
    chk("hold_err", 32'(err), 1);
    chk("hold_code", 32'(err_code), 2);
    chk("hold_count", 32'(err_count), 1);

    apply(0, 0, 1, 0);
    chk("recover_err", 32'(err), 0);

    apply(1, 1, 1, 1);
    chk("compl_code", 32'(err_code), 3);
    chk("compl_count", 32'(err_count), 2);

    // Gate toggling every sample, all legal
    apply(1, 1, 1, 0);
    apply(0, 0, 1, 0);
    apply(1, 0, 0, 1);
    apply(0, 1, 0, 1);
    chk("toggle_count", 32'(err_count), 2);

    // Asynchronous reset mid-hold
    rst_n = 1'b0;
    #1;
    chk("arst_err", 32'(err), 0);
    chk("arst_code", 32'(err_code), 0);
    chk("arst_count", 32'(err_count), 0);
    chk("arst_cycle", 32'(cycle), 0);
    #2;
    rst_n = 1'b1;
    repeat (3) apply(0, 0, 1, 1);
    chk("post_rst_err", 32'(err), 0);
    chk("post_rst_count", 32'(err_count), 0);

    // Saturation with repeated transparency errors
    apply(1, 1, 1, 0);
    sat_cyc = 32'(cycle);
    repeat (6) apply(1, 0, 1, 0);
    chk("sat_count", 32'(err_count), 3);
    chk("sat_code", 32'(err_code), 1);
`ifdef D_LATCH_CHECKER_STICKY_EN
    chk("sticky_valid", 32'(first_err_valid), 1);
    chk("sticky_code", 32'(first_err_code), 1);
    chk("sticky_cycle", 32'(first_err_cycle), 32'(sat_cyc));
`endif
    apply(1, 0, 0, 1);
    apply(1, 0, 0, 1);
    chk("final_count", 32'(err_count), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
